// File: rtl/seg_scan_driver_pkg.sv
// seg_pkg: shared converter states, segment patterns and display limits
package seg_pkg;
  typedef enum logic [2:0] {IDLE, DIV60, DIVM10, DIVS10, DONE} conv_state_t;
  localparam int MAX_SECONDS = 5999;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  // Active-low g..a pattern for a BCD digit; non-decimal codes go dark
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: time value, display controls and multiplexed display pins
interface seg_scan_driver_if;
  logic [13:0] seconds;
  logic blank;
  logic blank_lz;
  logic dp_en;
  logic [6:0] seg;
  logic dp;
  logic [3:0] an;
  logic busy;
  modport master (output seconds, blank, blank_lz, dp_en, input seg, dp, an, busy);
  modport slave (input seconds, blank, blank_lz, dp_en, output seg, dp, an, busy);
endinterface

// File: rtl/mmss_converter.sv
// mmss_converter: sequential binary seconds to MM:SS BCD digits by repeated subtraction
module mmss_converter #(
  parameter int MAX_SECONDS = seg_pkg::MAX_SECONDS
) (
  input  logic clock,
  input  logic reset,
  input  logic [13:0] seconds,
  output logic busy,
  output logic [3:0][3:0] digits
);
  import seg_pkg::*;
  conv_state_t state;
  logic [13:0] sat, val, last, rem;
  logic [6:0] mins;
  logic [3:0] mtens, stens;
  assign sat = seconds > 14'(MAX_SECONDS) ? 14'(MAX_SECONDS) : seconds;
  // Divide by 60, then split minutes and seconds into tens/units; digits publish atomically in DONE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      val <= '0;
      last <= '0;
      rem <= '0;
      mins <= '0;
      mtens <= '0;
      stens <= '0;
      digits <= '0;
    end else begin
      case (state)
        IDLE: if (sat != last) begin
          val <= sat;
          rem <= sat;
          mins <= '0;
          busy <= 1'b1;
          state <= DIV60;
        end
        DIV60: if (rem >= 14'd60) begin
          rem <= rem - 14'd60;
          mins <= mins + 7'd1;
        end else begin
          mtens <= '0;
          state <= DIVM10;
        end
        DIVM10: if (mins >= 7'd10) begin
          mins <= mins - 7'd10;
          mtens <= mtens + 4'd1;
        end else begin
          stens <= '0;
          state <= DIVS10;
        end
        DIVS10: if (rem >= 14'd10) begin
          rem <= rem - 14'd10;
          stens <= stens + 4'd1;
        end else begin
          state <= DONE;
        end
        DONE: begin
          digits <= {mtens, mins[3:0], stens, rem[3:0]};
          last <= val;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: MM:SS countdown display with time-multiplexed 4-digit 7-segment scan
module seg_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int MAX_SECONDS = seg_pkg::MAX_SECONDS
) (
  input logic clock,
  input logic reset,
  seg_scan_driver_if.slave bus
);
  import seg_pkg::*;
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  logic [CW-1:0] cnt;
  logic [1:0] idx, nidx;
  logic tc;
  logic [3:0][3:0] digits;
  logic [3:0] digit;
  mmss_converter #(.MAX_SECONDS(MAX_SECONDS)) u_conv (
    .clock(clock),
    .reset(reset),
    .seconds(bus.seconds),
    .busy(bus.busy),
    .digits(digits)
  );
  assign tc = cnt == CW'(REFRESH_DIV - 1);
  assign nidx = tc ? idx + 2'd1 : idx;
  assign digit = digits[nidx];
  // Outputs follow the upcoming slot so pins and index switch on the same edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
      bus.seg <= SEG_BLANK;
      bus.dp <= 1'b1;
      bus.an <= 4'hF;
    end else begin
      cnt <= tc ? '0 : cnt + 1'b1;
      idx <= nidx;
      bus.seg <= seg_decode(digit);
      bus.dp <= !(nidx == 2'd2 && bus.dp_en);
      bus.an <= (bus.blank || (nidx == 2'd3 && bus.blank_lz && digit == 4'd0)) ? 4'hF : ~(4'b0001 << nidx);
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed plus random checks of conversion and scan against an arithmetic model
module tb_seg_scan_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n;
  int prev;
  int val;
  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  seg_scan_driver_if bus();
  seg_scan_driver #(.REFRESH_DIV(4)) dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int sat_of(input int secs);
    return secs > 5999 ? 5999 : secs;
  endfunction
  function automatic int digit_of(input int secs, input int slot);
    int s, m, r;
    s = sat_of(secs);
    m = s / 60;
    r = s % 60;
    case (slot)
      0: return r % 10;
      1: return r / 10;
      2: return m % 10;
      default: return m / 10;
    endcase
  endfunction
  task automatic scan(input string tag, input int secs, input int cycles);
    int slot, d;
    logic [3:0] exp_an;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      slot = (cyc / 4) % 4;
      d = digit_of(secs, slot);
      exp_an = (bus.blank || (slot == 3 && bus.blank_lz && digit_of(secs, 3) == 0)) ? 4'hF : ~(4'b0001 << slot);
      chk({tag, ".an"}, bus.an, exp_an);
      chk({tag, ".dp"}, bus.dp, (slot == 2 && bus.dp_en) ? 0 : 1);
      if (exp_an != 4'hF) chk({tag, ".seg"}, bus.seg, pat[d]);
    end
  endtask
  task automatic wait_busy(input string tag, input logic v, input int bound, output int cnt);
    cnt = 0;
    while (bus.busy !== v && cnt < bound) begin
      @(negedge clk);
      cnt++;
    end
    chk(tag, bus.busy, v);
  endtask
  task automatic convert(input string tag, input int secs);
    bus.seconds = 14'(secs);
    wait_busy({tag, ".rise"}, 1'b1, 10, n);
    wait_busy({tag, ".fall"}, 1'b0, 130, n);
    chk({tag, ".len"}, n <= 120, 1);
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, ".an"}, bus.an, 4'hF);
    chk({tag, ".seg"}, bus.seg, 7'h7F);
    chk({tag, ".dp"}, bus.dp, 1);
    chk({tag, ".busy"}, bus.busy, 0);
  endtask
  initial begin
    bus.seconds = 0;
    bus.blank = 0;
    bus.blank_lz = 0;
    bus.dp_en = 0;
    repeat (3) @(negedge clk);
    reset_vals("reset");
    rst = 0;
    scan("idle0", 0, 8);
    chk("idle0.busy", bus.busy, 0);
    bus.dp_en = 1;
    convert("c125", 125);
    scan("s125", 125, 16);
    convert("c7000", 7000);
    scan("s7000", 7000, 16);
    bus.seconds = 125;
    wait_busy("r125.rise", 1'b1, 10, n);
    repeat (5) @(negedge clk);
    bus.seconds = 59;
    wait_busy("r125.fall", 1'b0, 130, n);
    chk("r125.len", n <= 120, 1);
    wait_busy("r59.rise", 1'b1, 3, n);
    scan("hold125", 125, 6);
    wait_busy("r59.fall", 1'b0, 130, n);
    scan("s59", 59, 16);
    bus.blank_lz = 1;
    convert("c65", 65);
    scan("s65", 65, 16);
    bus.blank = 1;
    scan("blank65", 65, 8);
    bus.blank = 0;
    prev = 65;
    for (int i = 0; i < 6; i++) begin
      val = int'($urandom_range(0, 16383));
      bus.blank_lz = 1'($urandom);
      bus.dp_en = 1'($urandom);
      if (sat_of(val) != sat_of(prev)) convert("crand", val);
      else bus.seconds = 14'(val);
      scan("srand", val, 16);
      prev = val;
    end
    bus.blank_lz = 0;
    convert("c100", 100);
    bus.seconds = 5999;
    wait_busy("rst.rise", 1'b1, 10, n);
    repeat (10) @(negedge clk);
    #2 rst = 1;
    #1 reset_vals("midrst");
    bus.seconds = 0;
    @(negedge clk);
    rst = 0;
    bus.blank = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("blankrst.an", bus.an, 4'hF);
      chk("blankrst.busy", bus.busy, 0);
    end
    bus.blank = 0;
    scan("post_rst", 0, 12);
    chk("post_rst.busy", bus.busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
